spi_ltc2335_multi_rd: RTL and testbench
=======================================

# spi_ltc2335_multi_rd

Parametrised SPI master that reads N_CH LTC2335-class ADCs in lockstep over a shared CS/SCK/SDO bus, each ADC on its own data line. Generated SCK is a divided copy of `clk`, and the capture point is programmable, so no delayed capture clock or ODDR is needed. The block adds a sequencer-programming transaction, trigger-overrun detection, and a per-frame valid strobe. It sits between the servo trigger logic and the ADC pins, and replaces the fixed two-ADC reader.

## Interface
Parameters:
- N_CH, 2: number of ADCs read in parallel (1..8).
- N_B, 24: bits per frame, MSB first (2..32).
- CLK_DIV, 2: SCK half-period in `clk` cycles (1..16).
- N_WAIT, 1: `clk` cycles from CS low to first SCK rise (1..15).
- SAMPLE_DLY, 1: capture offset in `clk` cycles after each SCK rise (0..2*CLK_DIV-1).
- N_CSH, 2: minimum CS-high cycles after a frame before `ready` returns (1..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- trigger  in  1  one-cycle request for a conversion read.
- cfg_req  in  1  one-cycle request for a sequencer write.
- data_in  in  N_B  word shifted on SDO during reads; latched at accept.
- cfg_word  in  N_B  word shifted on SDO during config writes; latched at accept.
- ovr_clr  in  1  clears `overrun`.
- sdi  in  N_CH  ADC serial data, bit k = ADC k.
- cs_n  out  N_CH  chip selects, active low, all driven identically.
- sck  out  1  serial clock, idles low.
- sdo  out  1  serial data to all ADCs.
- data_out  out  N_CH*N_B  captured frames; ADC k occupies bits [k*N_B +: N_B].
- valid  out  1  one-cycle strobe when `data_out` updates.
- cfg_done  out  1  one-cycle strobe at the end of a config write.
- ready  out  1  high when idle and able to accept a request.
- overrun  out  1  sticky flag: a request was dropped.
- state_out  out  3  current state encoding, for debug.

## Operation
- States: IDLE=0, CSW=1, SHIFT=2, HOLD=3. The mode bit, RD or CFG, is latched at accept.
- IDLE: `ready`=1. When `cfg_req` is high, latch `cfg_word` and enter CFG mode. Otherwise, when `trigger` is high, latch `data_in` and enter RD mode. Both cases go to CSW.
- Simultaneous `cfg_req` and `trigger` in IDLE: config wins; the trigger is dropped and `overrun` is set.
- CSW: `cs_n`=0, `sck`=0, `sdo`=latched MSB. After N_WAIT cycles, go to SHIFT.
- SHIFT: runs N_B SCK periods. `sck` is high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - `sdo` advances to the next bit on each SCK falling edge.
  - For each ADC, `sdi[k]` is shifted into a per-channel register SAMPLE_DLY cycles after each SCK rise.
  - Exactly N_B samples are taken per frame.
- After 2*CLK_DIV*N_B cycles in SHIFT, go to HOLD.
- HOLD entry cycle: `cs_n`=all 1, `sck`=0, `sdo`=0.
  - RD mode: `data_out` is loaded from the shift registers and `valid` pulses.
  - CFG mode: `data_out` is unchanged and `cfg_done` pulses.
- HOLD: after N_CSH cycles, return to IDLE.
- A `trigger` or `cfg_req` in any state other than IDLE is ignored and sets `overrun`.
- `overrun`: when set and `ovr_clr` occur in the same cycle, set wins.
- Bit counter and divider widths: bit counter is ceil(log2(N_B+1)) bits; divider counter is 5 bits. Neither counter may wrap inside a frame.

## Timing
- Reset values: `cs_n`=all 1, `sck`=0, `sdo`=0, `data_out`=0, `valid`=0, `cfg_done`=0, `ready`=1, `overrun`=0, `state_out`=0.
- Reset asserted mid-frame: outputs go to reset values asynchronously, and the partial frame is discarded.
- All outputs are registered.
- Request accepted at edge E0: `cs_n` falls at E0+1, `ready` falls at E0+1.
- First SCK rise: E0+1+N_WAIT.
- `valid`/`cfg_done` and `cs_n` rising: E0+1+N_WAIT+2*CLK_DIV*N_B.
- `ready` high again N_CSH cycles after that. The earliest next accept is that same edge.
- Capture order: the first sample lands in the MSB position of each channel's frame.

## Test plan
- Defaults; `sdi[0]` models 0xA5C3F1, `sdi[1]` models 0x123456 (update on SCK rise, with delay). Pulse `trigger` at E0 → `cs_n` low E0+1..E0+97, 24 SCK pulses of 4 cycles each, `valid` at E0+98, `data_out`=0x123456_A5C3F1, `ready` at E0+100.
- `cfg_word`=0x800000, `cfg_req` at E0 → `sdo` shows 1 then 23 zeros, each bit changing on SCK fall. `cfg_done` at E0+98. `valid` stays 0 and `data_out` is unchanged.
- `trigger` again at E0+40 during a read → frame completes normally and `overrun`=1. `ovr_clr` later → `overrun`=0. `ovr_clr` together with a dropped trigger → `overrun` stays 1.
- `trigger` and `cfg_req` in the same IDLE cycle → a CFG frame runs and `overrun`=1.
- `rst` low at E0+50 of a read → `cs_n`=all 1, `sck`=0, `data_out`=0 immediately. After release, `ready`=1 and the next trigger gives the full 98-cycle latency.
- Sweep CLK_DIV={1,3} and SAMPLE_DLY={0,2*CLK_DIV-1} with N_CH=4, N_B=16 → every channel captures its walking-ones pattern exactly; latency is 1+N_WAIT+2*CLK_DIV*16.

Source files
------------

// File: rtl/spi_ltc2335_multi_rd.sv
// SPI master that reads N_CH LTC2335-class ADCs in lockstep over a shared CS/SCK/SDO bus,
// and also issues sequencer-programming writes. Requests arriving while busy are flagged in overrun.
module spi_ltc2335_multi_rd #(
    parameter int N_CH       = 2,
    parameter int N_B        = 24,
    parameter int CLK_DIV    = 2,
    parameter int N_WAIT     = 1,
    parameter int SAMPLE_DLY = 1,
    parameter int N_CSH      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger,
    input  logic                 cfg_req,
    input  logic [N_B-1:0]       data_in,
    input  logic [N_B-1:0]       cfg_word,
    input  logic                 ovr_clr,
    input  logic [N_CH-1:0]      sdi,
    output logic [N_CH-1:0]      cs_n,
    output logic                 sck,
    output logic                 sdo,
    output logic [N_CH*N_B-1:0]  data_out,
    output logic                 valid,
    output logic                 cfg_done,
    output logic                 ready,
    output logic                 overrun,
    output logic [2:0]           state_out
);
    localparam int BW = $clog2(N_B + 1);
    localparam int DW = N_CH * N_B;
    localparam logic [4:0]    WAIT_LAST = 5'(N_WAIT - 1);
    localparam logic [4:0]    CSH_LAST  = 5'(N_CSH - 1);
    localparam logic [4:0]    HALF      = 5'(CLK_DIV);
    localparam logic [4:0]    DIV_LAST  = 5'(2 * CLK_DIV - 1);
    localparam logic [4:0]    SAMP      = 5'(SAMPLE_DLY);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N_B - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CSW   = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic            mode_cfg_q, mode_cfg_d;
    logic [4:0]      div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [N_B-1:0]  tx_q, tx_d;
    logic [DW-1:0]   rx_q, rx_d, dout_q, dout_d;
    logic            samp_q, samp_d;
    logic            cs_q, cs_d, sck_q, sck_d, sdo_q, sdo_d;
    logic            valid_q, valid_d, cfgd_q, cfgd_d, ready_q, ready_d, ovr_q, ovr_d;
    logic            hold_entry, req_drop;

    always_comb begin
        state_d    = state_q;
        mode_cfg_d = mode_cfg_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;

        // Pins lag the registered SCK by one clk edge, so the capture strobe is delayed by one
        // cycle: SAMPLE_DLY=0 samples the first edge that can see the ADC's post-rise data.
        if (samp_q) begin
            for (int k = 0; k < N_CH; k++) begin
                rx_d[k*N_B +: N_B] = {rx_q[k*N_B +: N_B-1], sdi[k]};
            end
        end

        case (state_q)
            IDLE: begin
                if (cfg_req || trigger) begin
                    mode_cfg_d = cfg_req;
                    tx_d       = cfg_req ? cfg_word : data_in;
                    rx_d       = '0;
                    div_d      = 5'd0;
                    state_d    = CSW;
                end
            end
            CSW: begin
                if (div_q == WAIT_LAST) begin
                    div_d   = 5'd0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 5'd1;
                end
            end
            SHIFT: begin
                if (div_q == HALF) begin
                    tx_d = {tx_q[N_B-2:0], 1'b0};
                end
                if (div_q == DIV_LAST) begin
                    div_d = 5'd0;
                    if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    div_d = div_q + 5'd1;
                end
            end
            HOLD: begin
                if (div_q == CSH_LAST) begin
                    div_d   = 5'd0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        hold_entry = (state_q == HOLD) && (div_q == 5'd0);
        req_drop   = ((state_q != IDLE) && (trigger || cfg_req)) ||
                     ((state_q == IDLE) && trigger && cfg_req);

        samp_d  = (state_q == SHIFT) && (div_q == SAMP);
        cs_d    = !((state_q == CSW) || (state_q == SHIFT));
        sck_d   = (state_q == SHIFT) && (div_q < HALF);
        sdo_d   = ((state_q == CSW) || (state_q == SHIFT)) ? tx_d[N_B-1] : 1'b0;
        valid_d = hold_entry && !mode_cfg_q;
        cfgd_d  = hold_entry && mode_cfg_q;
        dout_d  = valid_d ? rx_d : dout_q;
        ready_d = (state_q == IDLE);
        ovr_d   = req_drop || (ovr_q && !ovr_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mode_cfg_q <= 1'b0;
            div_q      <= 5'd0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            dout_q     <= '0;
            samp_q     <= 1'b0;
            cs_q       <= 1'b1;
            sck_q      <= 1'b0;
            sdo_q      <= 1'b0;
            valid_q    <= 1'b0;
            cfgd_q     <= 1'b0;
            ready_q    <= 1'b1;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_cfg_q <= mode_cfg_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            dout_q     <= dout_d;
            samp_q     <= samp_d;
            cs_q       <= cs_d;
            sck_q      <= sck_d;
            sdo_q      <= sdo_d;
            valid_q    <= valid_d;
            cfgd_q     <= cfgd_d;
            ready_q    <= ready_d;
            ovr_q      <= ovr_d;
        end
    end

    assign cs_n      = {N_CH{cs_q}};
    assign sck       = sck_q;
    assign sdo       = sdo_q;
    assign data_out  = dout_q;
    assign valid     = valid_q;
    assign cfg_done  = cfgd_q;
    assign ready     = ready_q;
    assign overrun   = ovr_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_spi_ltc2335_multi_rd.sv
// Bench for spi_ltc2335_multi_rd: default-parameter instance with behavioural ADC models,
// plus four N_CH=4/N_B=16 instances sweeping CLK_DIV and SAMPLE_DLY.
module tb_spi_ltc2335_multi_rd;
    localparam int N_CH = 2, N_B = 24, CLK_DIV = 2, N_WAIT = 1, SAMPLE_DLY = 1, N_CSH = 2;
    localparam int DW  = N_CH * N_B;
    localparam int LAT = 1 + N_WAIT + 2 * CLK_DIV * N_B;
    localparam int LIM = 200;

    logic            clk = 1'b0, rst = 1'b0;
    logic            trigger = 1'b0, cfg_req = 1'b0, ovr_clr = 1'b0;
    logic [N_B-1:0]  data_in = '0, cfg_word = '0;
    logic [N_CH-1:0] sdi = '0, cs_n;
    logic            sck, sdo, valid, cfg_done, ready, overrun;
    logic [DW-1:0]   data_out;
    logic [2:0]      state_out;

    int checks = 0, failures = 0;
    logic [N_B-1:0] adc_pat [N_CH];
    int             adc_idx = 0;
    logic [DW-1:0]  exp_dout = '0;

    // clock
    always #5 clk = ~clk;

    spi_ltc2335_multi_rd #(
        .N_CH(N_CH), .N_B(N_B), .CLK_DIV(CLK_DIV), .N_WAIT(N_WAIT),
        .SAMPLE_DLY(SAMPLE_DLY), .N_CSH(N_CSH)
    ) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .cfg_req(cfg_req),
        .data_in(data_in), .cfg_word(cfg_word), .ovr_clr(ovr_clr), .sdi(sdi),
        .cs_n(cs_n), .sck(sck), .sdo(sdo), .data_out(data_out), .valid(valid),
        .cfg_done(cfg_done), .ready(ready), .overrun(overrun), .state_out(state_out)
    );

    // ADC model: presents the next frame bit shortly after each SCK rise, MSB first.
    always @(negedge cs_n[0]) adc_idx = 0;
    always @(posedge sck) begin
        #1;
        for (int k = 0; k < N_CH; k++)
            sdi[k] = (adc_idx < N_B) ? adc_pat[k][N_B-1-adc_idx] : 1'b0;
        adc_idx++;
    end

    // sweep instances
    logic [3:0]  sw_trig = '0;
    logic [3:0]  sw_valid, sw_rdy;
    logic [63:0] sw_dout [4];
    logic [15:0] sw_pat [4];

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int CD = (g < 2) ? 1 : 3;
        localparam int SD = (g % 2 == 0) ? 0 : 2 * CD - 1;
        logic [3:0]  cs_w;
        logic [3:0]  sdi_w = '0;
        logic        sck_w, sdo_w, valid_w, cfgd_w, rdy_w, ovr_w;
        logic [63:0] dout_w;
        logic [2:0]  st_w;
        int          idx = 0;

        spi_ltc2335_multi_rd #(
            .N_CH(4), .N_B(16), .CLK_DIV(CD), .N_WAIT(1), .SAMPLE_DLY(SD), .N_CSH(2)
        ) u_sw (
            .clk(clk), .rst(rst), .trigger(sw_trig[g]), .cfg_req(1'b0),
            .data_in(16'h0), .cfg_word(16'h0), .ovr_clr(1'b0), .sdi(sdi_w),
            .cs_n(cs_w), .sck(sck_w), .sdo(sdo_w), .data_out(dout_w), .valid(valid_w),
            .cfg_done(cfgd_w), .ready(rdy_w), .overrun(ovr_w), .state_out(st_w)
        );

        always @(negedge cs_w[0]) idx = 0;
        always @(posedge sck_w) begin
            #1;
            for (int k = 0; k < 4; k++)
                sdi_w[k] = (idx < 16) ? sw_pat[k][15-idx] : 1'b0;
            idx++;
        end

        assign sw_valid[g] = valid_w;
        assign sw_rdy[g]   = rdy_w;
        assign sw_dout[g]  = dout_w;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic new_pats();
        for (int k = 0; k < N_CH; k++) adc_pat[k] = N_B'($urandom);
    endtask

    // req: 0 read, 1 config, 2 trigger+cfg_req together. ovr_mode: 1 trigger at E0+40, 2 also ovr_clr.
    task automatic run_frame(input int req, input int ovr_mode, input logic [N_B-1:0] word,
                             input logic exp_ovr);
        int n_csf, n_csr, n_sck1, n_done, n_rdyf, n_rdy, n_pulse, n_valid, n_cfgd, glitch, csdiff;
        logic [N_B-1:0] bits;
        logic p_sck, p_sdo, p_cs;
        bit is_cfg;
        is_cfg = (req != 0);
        n_csf = -1; n_csr = -1; n_sck1 = -1; n_done = -1; n_rdyf = -1; n_rdy = -1;
        n_pulse = 0; n_valid = 0; n_cfgd = 0; glitch = 0; csdiff = 0; bits = '0;
        @(negedge clk);
        if (is_cfg) begin
            cfg_word = word; data_in = N_B'($urandom);
        end else begin
            data_in = word; cfg_word = N_B'($urandom);
        end
        trigger = (req != 1);
        cfg_req = is_cfg;
        @(posedge clk); #1;
        trigger = 1'b0; cfg_req = 1'b0;
        p_sck = sck; p_sdo = sdo; p_cs = cs_n[0];
        for (int n = 1; n <= LIM && n_rdy < 0; n++) begin
            if (n == 40 && ovr_mode != 0) begin
                trigger = 1'b1;
                ovr_clr = (ovr_mode == 2);
            end
            @(posedge clk); #1;
            trigger = 1'b0; ovr_clr = 1'b0;
            if (cs_n != {N_CH{cs_n[0]}}) csdiff++;
            if (p_cs && !cs_n[0] && n_csf < 0) n_csf = n;
            if (!p_cs && cs_n[0] && n_csr < 0) n_csr = n;
            if (!ready && n_rdyf < 0) n_rdyf = n;
            if (ready && n_csr > 0 && n_rdy < 0) n_rdy = n;
            if (sck && !p_sck) begin
                n_pulse++;
                if (n_sck1 < 0) n_sck1 = n;
                bits = {bits[N_B-2:0], sdo};
            end
            if (sdo != p_sdo && !(p_sck && !sck) && n != n_csf && n != n_csr) glitch++;
            if (valid) begin n_valid++; n_done = n; end
            if (cfg_done) begin n_cfgd++; n_done = n; end
            p_sck = sck; p_sdo = sdo; p_cs = cs_n[0];
        end
        if (!is_cfg)
            for (int k = 0; k < N_CH; k++) exp_dout[k*N_B +: N_B] = adc_pat[k];
        check("cs_fall", n_csf, 1);
        check("ready_fall", n_rdyf, 1);
        check("sck_first", n_sck1, 1 + N_WAIT);
        check("sck_count", n_pulse, N_B);
        check("sdo_bits", bits, word);
        check("sdo_on_fall", glitch, 0);
        check("cs_equal", csdiff, 0);
        check("done_time", n_done, LAT);
        check("cs_rise", n_csr, LAT);
        check("ready_rise", n_rdy, LAT + N_CSH);
        check("valid_count", n_valid, is_cfg ? 0 : 1);
        check("cfgdone_count", n_cfgd, is_cfg ? 1 : 0);
        check("data_out", data_out, exp_dout);
        check("overrun", overrun, exp_ovr);
    endtask

    task automatic pulse_clr();
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        check("ovr_cleared", overrun, 1'b0);
    endtask

    task automatic sweep_frame(input int g, input int f);
        int lat, cd;
        logic [63:0] exp;
        cd = (g < 2) ? 1 : 3;
        lat = -1;
        for (int n = 0; n < 20 && !sw_rdy[g]; n++) begin @(posedge clk); #1; end
        for (int k = 0; k < 4; k++) begin
            sw_pat[k] = 16'h0001 << ((f + 4 * k) % 16);
            exp[k*16 +: 16] = sw_pat[k];
        end
        @(negedge clk); sw_trig[g] = 1'b1;
        @(posedge clk); #1; sw_trig[g] = 1'b0;
        for (int n = 1; n <= LIM && lat < 0; n++) begin
            @(posedge clk); #1;
            if (sw_valid[g]) lat = n;
        end
        check($sformatf("sw%0d_latency", g), lat, 1 + 1 + 2 * cd * 16);
        check($sformatf("sw%0d_data", g), sw_dout[g], exp);
    endtask

    initial begin
        for (int k = 0; k < N_CH; k++) adc_pat[k] = '0;
        for (int k = 0; k < 4; k++) sw_pat[k] = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_cs_n", cs_n, {N_CH{1'b1}});
        check("rst_sck", sck, 1'b0);
        check("rst_sdo", sdo, 1'b0);
        check("rst_data_out", data_out, '0);
        check("rst_valid", valid, 1'b0);
        check("rst_cfg_done", cfg_done, 1'b0);
        check("rst_ready", ready, 1'b1);
        check("rst_overrun", overrun, 1'b0);
        check("rst_state", state_out, 3'd0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);

        adc_pat[0] = 24'hA5C3F1;
        adc_pat[1] = 24'h123456;
        run_frame(0, 0, N_B'($urandom), 1'b0);
        check("known_frame", data_out, 48'h123456_A5C3F1);
        run_frame(1, 0, 24'h800000, 1'b0);

        for (int i = 0; i < 4; i++) begin
            new_pats();
            run_frame($urandom_range(0, 1), 0, N_B'($urandom), 1'b0);
        end

        new_pats();
        run_frame(0, 1, N_B'($urandom), 1'b1);
        pulse_clr();
        new_pats();
        run_frame(0, 2, N_B'($urandom), 1'b1);
        pulse_clr();
        new_pats();
        run_frame(2, 0, N_B'($urandom), 1'b1);
        pulse_clr();

        // reset in the middle of a read
        new_pats();
        @(negedge clk); data_in = N_B'($urandom); trigger = 1'b1;
        @(posedge clk); #1; trigger = 1'b0;
        repeat (49) @(posedge clk);
        #2; rst = 1'b0; #1;
        check("mid_rst_cs_n", cs_n, {N_CH{1'b1}});
        check("mid_rst_sck", sck, 1'b0);
        check("mid_rst_sdo", sdo, 1'b0);
        check("mid_rst_data_out", data_out, '0);
        check("mid_rst_ready", ready, 1'b1);
        check("mid_rst_state", state_out, 3'd0);
        exp_dout = '0;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        new_pats();
        run_frame(0, 0, N_B'($urandom), 1'b0);

        for (int g = 0; g < 4; g++)
            for (int f = 0; f < 4; f++)
                sweep_frame(g, f);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
